// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: each channel divides clk_sys by a runtime ratio and emits
// single-cycle enable pulses plus a square wave, with shadowed ratio updates and one-shot mode.
module clk_enable_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    restart,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       ch_oneshot,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  input  logic [NUM_CH*DIV_W-1:0] ch_phase,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       sq,
  output logic [NUM_CH-1:0]       done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_req, phase_req, phase_clamp;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;
    logic             sq_q, sq_d;
    logic             done_q, done_d;

    assign div_req     = ch_div[i*DIV_W +: DIV_W];
    assign phase_req   = ch_phase[i*DIV_W +: DIV_W];
    // Clamping the load value keeps cnt within div_act, so terminal detection is a plain compare.
    assign phase_clamp = (phase_req > div_req) ? div_req : phase_req;

    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      ce_d   = 1'b0;
      sq_d   = sq_q;
      done_d = done_q;
      if (restart) begin
        div_d  = div_req;
        cnt_d  = phase_clamp;
        sq_d   = 1'b0;
        done_d = 1'b0;
      end else if (!done_q && ch_en[i]) begin
        if (cnt_q == div_q) begin
          // New ratio is adopted only here, so the running period is never cut short.
          cnt_d = '0;
          div_d = div_req;
          ce_d  = 1'b1;
          sq_d  = ~sq_q;
          if (ch_oneshot[i]) begin
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        div_q  <= DIV_W'(DEFAULT_DIV);
        ce_q   <= 1'b0;
        sq_q   <= 1'b0;
        done_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        ce_q   <= ce_d;
        sq_q   <= sq_d;
        done_q <= done_d;
      end
    end

    assign ce[i]   = ce_q;
    assign sq[i]   = sq_q;
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: countdown-based reference model checked every cycle, plus directed
// literal expectations from hand-worked timing.
module tb_clk_enable_gen;

  localparam int NCH = 4;
  localparam int DW  = 4;
  localparam int DEF = 2;

  logic                clk_sys = 1'b0;
  logic                reset_n;
  logic                restart;
  logic [NCH-1:0]      ch_en;
  logic [NCH-1:0]      ch_oneshot;
  logic [NCH*DW-1:0]   ch_div;
  logic [NCH*DW-1:0]   ch_phase;
  logic [NCH-1:0]      ce, sq, done;

  int n_checks = 0;
  int n_fail   = 0;

  clk_enable_gen #(
    .NUM_CH     (NCH),
    .DIV_W      (DW),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .restart   (restart),
    .ch_en     (ch_en),
    .ch_oneshot(ch_oneshot),
    .ch_div    (ch_div),
    .ch_phase  (ch_phase),
    .ce        (ce),
    .sq        (sq),
    .done      (done)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: cycles remaining until the next pulse, the adopted period, and output flags.
  int   m_left [NCH];
  int   m_per  [NCH];
  logic m_ce   [NCH];
  logic m_sq   [NCH];
  logic m_done [NCH];

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_left[c] <= DEF;
        m_per[c]  <= DEF;
        m_ce[c]   <= 1'b0;
        m_sq[c]   <= 1'b0;
        m_done[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        automatic int d = int'(ch_div[c*DW +: DW]);
        automatic int p = int'(ch_phase[c*DW +: DW]);
        if (restart) begin
          m_per[c]  <= d;
          m_left[c] <= d - ((p < d) ? p : d);
          m_ce[c]   <= 1'b0;
          m_sq[c]   <= 1'b0;
          m_done[c] <= 1'b0;
        end else if (m_done[c] || !ch_en[c]) begin
          m_ce[c] <= 1'b0;
        end else if (m_left[c] == 0) begin
          m_ce[c]   <= 1'b1;
          m_sq[c]   <= ~m_sq[c];
          m_per[c]  <= d;
          m_left[c] <= d;
          if (ch_oneshot[c]) m_done[c] <= 1'b1;
        end else begin
          m_left[c] <= m_left[c] - 1;
          m_ce[c]   <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    if (reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("model ce[%0d]", c), int'(ce[c]), int'(m_ce[c]));
        check($sformatf("model sq[%0d]", c), int'(sq[c]), int'(m_sq[c]));
        check($sformatf("model done[%0d]", c), int'(done[c]), int'(m_done[c]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic set_ch(input int c, input int d, input int p, input bit en, input bit os);
    ch_div[c*DW +: DW]   = DW'(d);
    ch_phase[c*DW +: DW] = DW'(p);
    ch_en[c]             = en;
    ch_oneshot[c]        = os;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    restart    = 1'b0;
    ch_en      = '0;
    ch_oneshot = '0;
    ch_div     = '0;
    ch_phase   = '0;
    #12;
    check("reset ce", int'(ce), 0);
    check("reset sq", int'(sq), 0);
    check("reset done", int'(done), 0);
    step(1);
    reset_n = 1'b1;

    // DEFAULT_DIV=2 is active after reset: first pulse on the third edge with no restart.
    ch_en[3] = 1'b1;
    ch_div[3*DW +: DW] = DW'(DEF);
    step(2);
    check("default div no pulse", int'(ce[3]), 0);
    step(1);
    check("default div pulse", int'(ce[3]), 1);

    // Free-run D=3 on ch0 and D=0 on ch1.
    set_ch(0, 3, 0, 1'b1, 1'b0);
    set_ch(1, 0, 0, 1'b1, 1'b0);
    set_ch(3, 0, 0, 1'b0, 1'b0);
    do_restart();
    check("restart clears ce0", int'(ce[0]), 0);
    check("restart clears sq0", int'(sq[0]), 0);
    step(1);
    check("d0 ce e1", int'(ce[1]), 1);
    check("d0 sq e1", int'(sq[1]), 1);
    check("d3 ce e1", int'(ce[0]), 0);
    step(1);
    check("d0 ce e2", int'(ce[1]), 1);
    check("d0 sq e2", int'(sq[1]), 0);
    step(1);
    check("d3 ce e3", int'(ce[0]), 0);
    step(1);
    check("d3 ce e4", int'(ce[0]), 1);
    check("d3 sq e4", int'(sq[0]), 1);
    step(4);
    check("d3 ce e8", int'(ce[0]), 1);
    check("d3 sq e8", int'(sq[0]), 0);
    step(4);
    check("d3 ce e12", int'(ce[0]), 1);
    check("d3 sq e12", int'(sq[0]), 1);

    // Shadow update: write D=1 at cnt=1, current period still completes at D=3.
    step(1);
    ch_div[0*DW +: DW] = DW'(1);
    step(2);
    check("shadow old period", int'(ce[0]), 0);
    step(1);
    check("shadow old term", int'(ce[0]), 1);
    step(1);
    check("shadow new gap", int'(ce[0]), 0);
    step(1);
    check("shadow new p1", int'(ce[0]), 1);
    step(2);
    check("shadow new p2", int'(ce[0]), 1);

    // Phase load and clamp on ch2.
    set_ch(2, 5, 4, 1'b1, 1'b0);
    do_restart();
    step(1);
    check("phase4 e1", int'(ce[2]), 0);
    step(1);
    check("phase4 e2", int'(ce[2]), 1);
    set_ch(2, 5, 9, 1'b1, 1'b0);
    do_restart();
    step(1);
    check("phase clamp e1", int'(ce[2]), 1);

    // One-shot D=2 on ch3.
    set_ch(3, 2, 0, 1'b1, 1'b1);
    do_restart();
    step(2);
    check("oneshot e2", int'(ce[3]), 0);
    step(1);
    check("oneshot e3 ce", int'(ce[3]), 1);
    check("oneshot e3 done", int'(done[3]), 1);
    ch_oneshot[3] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      check("oneshot halted ce", int'(ce[3]), 0);
    end
    check("oneshot done sticky", int'(done[3]), 1);
    ch_oneshot[3] = 1'b1;
    do_restart();
    check("rearm done clr", int'(done[3]), 0);
    step(3);
    check("rearm ce", int'(ce[3]), 1);

    // Enable gating on ch2 at cnt=2, D=4.
    set_ch(2, 4, 0, 1'b1, 1'b0);
    do_restart();
    step(2);
    ch_en[2] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step(1);
      check("gated ce", int'(ce[2]), 0);
    end
    ch_en[2] = 1'b1;
    step(2);
    check("resume e2", int'(ce[2]), 0);
    step(1);
    check("resume e3", int'(ce[2]), 1);

    // Full-range ratio D=15 on ch1: period 16.
    set_ch(1, 15, 0, 1'b1, 1'b0);
    do_restart();
    step(15);
    check("wrap e15", int'(ce[1]), 0);
    step(1);
    check("wrap e16", int'(ce[1]), 1);

    // Asynchronous reset mid-count, between edges.
    step(5);
    #2;
    reset_n = 1'b0;
    #1;
    check("async ce", int'(ce), 0);
    check("async sq", int'(sq), 0);
    check("async done", int'(done), 0);
    step(2);
    reset_n = 1'b1;
    step(10);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
